// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller for a flag-less circular fifo.
// Tracks occupancy from the mirrored write strobe and drains words into a valid/ready stage with frame markers.
module fifo_drain #(
  parameter int DATA_WIDTH = 25,
  parameter int DEPTH      = 256,
  parameter int FRAME_LEN  = 16,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_strobe,
  input  logic [DATA_WIDTH-1:0] fifo_do,
  output logic                  fifo_rden,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mData_q, mData_d;
  logic                  mValid_q, mValid_d;
  logic                  mLast_q, mLast_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  overflow_q, overflow_d;
  logic                  isEmpty, isFull;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == DEPTH_C);

  // Pop whenever a word is queued and the output stage is free or being drained this cycle.
  assign fifo_rden = !isEmpty && (!mValid_q || m_ready);

  always_comb begin
    count_d    = count_q;
    mData_d    = mData_q;
    mValid_d   = mValid_q;
    mLast_d    = mLast_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;

    unique case ({wr_strobe, fifo_rden})
      2'b10: begin
        if (!isFull) begin
          count_d = count_q + CW'(1);
        end
      end
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A write into a full fifo with no pop has overwritten an unread word.
    if (wr_strobe && isFull && !fifo_rden) begin
      overflow_d = 1'b1;
    end

    if (fifo_rden) begin
      mData_d  = fifo_do;
      mValid_d = 1'b1;
      mLast_d  = (beat_q == LAST_BEAT);
      beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    end else if (mValid_q && m_ready) begin
      mValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      mData_q    <= '0;
      mValid_q   <= 1'b0;
      mLast_q    <= 1'b0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      mData_q    <= mData_d;
      mValid_q   <= mValid_d;
      mLast_q    <= mLast_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_data   = mData_q;
  assign m_valid  = mValid_q;
  assign m_last   = mLast_q;
  assign count    = count_q;
  assign empty    = isEmpty;
  assign full     = isFull;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: drives fifo_drain next to an emulated flag-less circular fifo and
// checks it against a queue-based model of occupancy, output stage and frame beats.
module tb_fifo_drain;

  localparam int DW    = 25;
  localparam int DEPTH = 256;
  localparam int FL    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          wr_strobe;
  logic [DW-1:0] wrData;
  logic [DW-1:0] fifo_do;
  logic          fifo_rden;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic          expValid;
  logic [DW-1:0] expData;
  logic          expLast;
  logic          expOverflow;
  int            beatNum;

  logic [DW-1:0] mem [DEPTH];
  logic [7:0]    wptr, rptr;

  fifo_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_strobe (wr_strobe),
    .fifo_do   (fifo_do),
    .fifo_rden (fifo_rden),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the paired circular fifo: no flags, DO is a combinational read.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_strobe) begin
        mem[wptr] <= wrData;
        wptr      <= wptr + 8'd1;
      end
      if (fifo_rden) rptr <= rptr + 8'd1;
    end
  end
  assign fifo_do = mem[rptr];

  task automatic clearModel();
    q.delete();
    expValid    = 1'b0;
    expData     = '0;
    expLast     = 1'b0;
    expOverflow = 1'b0;
    beatNum     = 0;
  endtask

  // One clock: drive inputs, advance the model by the pop/accept/write rules, wait past the edge.
  task automatic tick(input logic wr, input logic [DW-1:0] d, input logic rdy);
    logic pop;
    wr_strobe = wr;
    wrData    = d;
    m_ready   = rdy;
    pop = (q.size() != 0) && (!expValid || rdy);
    if (pop) begin
      expData  = q.pop_front();
      expValid = 1'b1;
      expLast  = ((beatNum % FL) == FL - 1);
      beatNum++;
    end else if (expValid && rdy) begin
      expValid = 1'b0;
    end
    if (wr) begin
      if (q.size() < DEPTH) q.push_back(d);
      else expOverflow = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    wr_strobe = 1'b0;
    wrData    = '0;
    m_ready   = 1'b1;
    rst       = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", m_data); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", m_last); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, '0, 1'b1);
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL idle_empty[%0d]: got %b expected 1", i, empty); end
      checks++; if (count !== '0) begin errors++; $display("[TB] FAIL idle_count[%0d]: got %0d expected 0", i, count); end
      checks++; if (fifo_rden !== 1'b0) begin errors++; $display("[TB] FAIL idle_rden[%0d]: got %b expected 0", i, fifo_rden); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid[%0d]: got %b expected 0", i, m_valid); end
    end
  endtask

  task automatic test_stream();
    int firstValid = -1;
    logic [DW-1:0] got[$];
    logic [DW-1:0] want;
    doReset();
    for (int k = 0; k < 12; k++) begin
      tick(k < 5, DW'(32'h10 + k), 1'b1);
      if (m_valid === 1'b1) begin
        if (firstValid < 0) firstValid = k;
        got.push_back(m_data);
      end
      checks++; if (m_valid !== expValid) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", k, m_valid, expValid); end
      checks++; if (count !== CW'(q.size())) begin errors++; $display("[TB] FAIL stream_count[%0d]: got %0d expected %0d", k, count, q.size()); end
    end
    checks++; if (firstValid != 1) begin errors++; $display("[TB] FAIL stream_latency: got %0d expected 1", firstValid); end
    checks++; if (got.size() != 5) begin errors++; $display("[TB] FAIL stream_beats: got %0d expected 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      want = DW'(32'h10 + i);
      checks++; if (got[i] !== want) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %0h expected %0h", i, got[i], want); end
    end
    checks++; if (count !== '0) begin errors++; $display("[TB] FAIL stream_drained: got %0d expected 0", count); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] words[8];
    logic [DW-1:0] got[$];
    doReset();
    for (int i = 0; i < 8; i++) begin
      words[i] = DW'($urandom);
      tick(1'b1, words[i], 1'b0);
    end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== words[0]) begin errors++; $display("[TB] FAIL bp_hold: got %0h expected %0h", m_data, words[0]); end
    checks++; if (count !== CW'(7)) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 7", count); end
    for (int i = 0; i < 10; i++) begin
      if (m_valid === 1'b1) got.push_back(m_data);
      tick(1'b0, '0, 1'b1);
      checks++; if (m_valid !== expValid) begin errors++; $display("[TB] FAIL bp_drain_valid[%0d]: got %b expected %b", i, m_valid, expValid); end
      if (expValid) begin
        checks++; if (m_data !== expData) begin errors++; $display("[TB] FAIL bp_drain_data[%0d]: got %0h expected %0h", i, m_data, expData); end
      end
    end
    checks++; if (got.size() != 8) begin errors++; $display("[TB] FAIL bp_beats: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== words[i]) begin errors++; $display("[TB] FAIL bp_order[%0d]: got %0h expected %0h", i, got[i], words[i]); end
    end
  endtask

  task automatic test_frame_last();
    int idx = 0;
    doReset();
    for (int k = 0; k < 16; k++) begin
      tick(k < 12, DW'($urandom), 1'b1);
      if (m_valid === 1'b1) begin
        checks++; if (m_last !== ((idx % 4) == 3)) begin errors++; $display("[TB] FAIL frame_last[%0d]: got %b expected %b", idx, m_last, ((idx % 4) == 3)); end
        checks++; if (m_data !== expData) begin errors++; $display("[TB] FAIL frame_data[%0d]: got %0h expected %0h", idx, m_data, expData); end
        idx++;
      end
    end
    checks++; if (idx != 12) begin errors++; $display("[TB] FAIL frame_beats: got %0d expected 12", idx); end
  endtask

  task automatic test_full_overflow();
    doReset();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, DW'($urandom), 1'b0);
    checks++; if (count !== CW'(255)) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 255", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: got %b expected 0", full); end
    tick(1'b1, DW'($urandom), 1'b0);
    checks++; if (count !== CW'(256)) begin errors++; $display("[TB] FAIL full_count: got %0d expected 256", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: got %b expected 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_no_ovf: got %b expected 0", overflow); end
    tick(1'b1, DW'($urandom), 1'b1);
    checks++; if (count !== CW'(256)) begin errors++; $display("[TB] FAIL wrpop_count: got %0d expected 256", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL wrpop_no_ovf: got %b expected 0", overflow); end
    checks++; if (m_data !== expData) begin errors++; $display("[TB] FAIL wrpop_data: got %0h expected %0h", m_data, expData); end
    tick(1'b1, DW'($urandom), 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (count !== CW'(256)) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 256", count); end
    tick(1'b1, DW'($urandom), 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    checks++; if (count !== CW'(256)) begin errors++; $display("[TB] FAIL ovf_wrpop_count: got %0d expected 256", count); end
    tick(1'b0, '0, 1'b1);
    checks++; if (overflow !== expOverflow) begin errors++; $display("[TB] FAIL ovf_model: got %b expected %b", overflow, expOverflow); end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    doReset();
    for (int i = 0; i < 31; i++) tick(1'b1, DW'($urandom), 1'b0);
    checks++; if (count !== CW'(30)) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 30", count); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 1", m_valid); end
    wr_strobe = 1'b0;
    m_ready   = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (count !== '0) begin errors++; $display("[TB] FAIL async_count: got %0d expected 0", count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid: got %b expected 0", m_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL async_empty: got %b expected 1", empty); end
    checks++; if (m_data !== '0) begin errors++; $display("[TB] FAIL async_data: got %0h expected 0", m_data); end
    checks++; if (fifo_rden !== 1'b0) begin errors++; $display("[TB] FAIL async_rden: got %b expected 0", fifo_rden); end
    clearModel();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(k < 8, DW'($urandom), 1'b1);
      if (m_valid === 1'b1) begin
        checks++; if (m_last !== ((idx % 4) == 3)) begin errors++; $display("[TB] FAIL restart_last[%0d]: got %b expected %b", idx, m_last, ((idx % 4) == 3)); end
        checks++; if (m_data !== expData) begin errors++; $display("[TB] FAIL restart_data[%0d]: got %0h expected %0h", idx, m_data, expData); end
        idx++;
      end
    end
    checks++; if (idx != 8) begin errors++; $display("[TB] FAIL restart_beats: got %0d expected 8", idx); end
  endtask

  task automatic test_random();
    logic wr, rdy, expRden;
    doReset();
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom_range(0, 1) == 1) && (q.size() < 240);
      rdy = ($urandom_range(0, 3) != 0);
      tick(wr, DW'($urandom), rdy);
      expRden = (q.size() != 0) && (!expValid || rdy);
      checks++; if (count !== CW'(q.size())) begin errors++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, count, q.size()); end
      checks++; if (m_valid !== expValid) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, m_valid, expValid); end
      checks++; if (fifo_rden !== expRden) begin errors++; $display("[TB] FAIL rnd_rden[%0d]: got %b expected %b", i, fifo_rden, expRden); end
      if (expValid) begin
        checks++; if (m_data !== expData) begin errors++; $display("[TB] FAIL rnd_data[%0d]: got %0h expected %0h", i, m_data, expData); end
        checks++; if (m_last !== expLast) begin errors++; $display("[TB] FAIL rnd_last[%0d]: got %b expected %b", i, m_last, expLast); end
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    wr_strobe = 1'b0;
    wrData    = '0;
    m_ready   = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_frame_last();
    test_full_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
